// File: rtl/stoch_ser_pkg.sv
// Shared constants and types for the stochastic serial link (serializer and receivers).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stoch_ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GUARD = 2'd2,
    ST_GAP   = 2'd3
  } ser_state_t;

  localparam int PROB_W         = 9;
  localparam int FRAME_BITS     = 10;
  localparam int GAP_W          = 17;
  localparam int GAP_CYCLES_DEF = 131068;

endpackage

// File: rtl/prob_word_serializer_if.sv
// Word-in / serial-out bundle between a probability source and the serializer.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready handshake; ready is low for the whole frame.
interface prob_word_serializer_if;
  import stoch_ser_pkg::*;

  logic              in_valid;
  logic [PROB_W-1:0] in_data;
  logic              in_ready;
  logic              ser_out;
  logic              frame_sync;
  logic              busy;

  modport master (
    output in_valid, in_data,
    input  in_ready, ser_out, frame_sync, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ser_out, frame_sync, busy
  );

endinterface

// File: rtl/ser_gap_timer.sv
// Loadable 17-bit down-counter; done marks the last cycle of a loaded interval.
// Latency: a load of N gives exactly N cycles up to and including the done cycle.
// Backpressure: none; counts freely and holds at zero instead of wrapping.
module ser_gap_timer
  import stoch_ser_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  output logic             done
);

  logic [GAP_W-1:0] cnt_q;

  // Load on request, otherwise count down and saturate at zero.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - GAP_W'(1);
    end
  end

  assign done = (cnt_q == GAP_W'(1));

endmodule

// File: rtl/prob_word_serializer.sv
// Serializes a 9-bit probability word LSB first, then a guard bit, then GAP_CYCLES idle cycles.
// Latency: bit 0 appears on ser_out the cycle after accept; frame period 11+GAP_CYCLES cycles.
// Backpressure: in_ready only in IDLE; optional SER_PARITY_EN puts even parity in the guard slot.
module prob_word_serializer
  import stoch_ser_pkg::*;
#(
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  prob_word_serializer_if.slave bus
);

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam logic [3:0]       LAST_BIT = 4'(PROB_W - 1);

  ser_state_t        state_q;
  ser_state_t        state_d;
  logic [3:0]        bit_cnt_q;
  logic [PROB_W-1:0] shreg_q;
  logic              ser_out_q;
  logic              ready;
  logic              accept;
  logic              gap_load;
  logic              gap_done;
  logic              sync;
  logic              guard_bit;

`ifdef SER_PARITY_EN
  assign guard_bit = ^shreg_q;
`else
  assign guard_bit = 1'b0;
`endif

  assign accept = bus.in_valid & ready;

  // State register; reset aborts any frame in flight immediately.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: IDLE -> SHIFT x9 -> GUARD x1 -> GAP xN -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (bit_cnt_q == LAST_BIT) state_d = ST_GUARD;
      ST_GUARD: state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:   if (gap_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Status outputs; ready is held low while reset is asserted.
  always_comb begin
    ready    = 1'b0;
    sync     = 1'b0;
    gap_load = 1'b0;
    case (state_q)
      ST_IDLE:  ready    = ~rst_n;
      ST_SHIFT: sync     = (bit_cnt_q == 4'd0);
      ST_GUARD: gap_load = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: latch word on accept, present one bit per cycle, then guard and idle zeros.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      ser_out_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            shreg_q   <= bus.in_data;
            bit_cnt_q <= '0;
            ser_out_q <= bus.in_data[0];
          end
        end
        ST_SHIFT: begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_q <= '0;
            ser_out_q <= guard_bit;
          end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
            ser_out_q <= shreg_q[bit_cnt_q + 4'd1];
          end
        end
        default: ser_out_q <= 1'b0;
      endcase
    end
  end

  ser_gap_timer u_gap (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .done     (gap_done)
  );

  assign bus.in_ready   = ready;
  assign bus.ser_out    = ser_out_q;
  assign bus.frame_sync = sync;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_prob_word_serializer.sv
// Bench for prob_word_serializer: table-driven frames, hand sequences, random traffic vs model.
// The gap is shortened to 4 cycles so the run stays small; the guard expectation follows SER_PARITY_EN.
module tb_prob_word_serializer;
  import stoch_ser_pkg::*;

  localparam int G = 4;
`ifdef SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  prob_word_serializer_if bus ();

  prob_word_serializer #(.GAP_CYCLES(G)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [8:0] data;
    bit         par;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for ready, sends one word, and acts as the loopback receiver.
  task automatic run_frame(input logic [8:0] w, input bit exp_guard, input string tag);
    int         waitc;
    logic [8:0] rx;
    waitc = 0;
    while (bus.in_ready !== 1'b1 && waitc < 100) begin
      tick();
      waitc++;
    end
    chk({tag, "_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = ~w;
    rx = '0;
    for (int k = 0; k < 9; k++) begin
      rx[k] = bus.ser_out;
      chk({tag, "_sync"}, bus.frame_sync, (k == 0) ? 1 : 0);
      if (k == 0 || k == 8) chk({tag, "_busy"}, bus.busy, 1);
      tick();
    end
    chk({tag, "_rx"}, rx, w);
    chk({tag, "_guard"}, bus.ser_out, exp_guard);
    chk({tag, "_guard_ready"}, bus.in_ready, 0);
    tick();
    for (int i = 0; i < G; i++) begin
      chk({tag, "_gap"}, {bus.ser_out, bus.in_ready, bus.busy}, 3'b001);
      tick();
    end
    chk({tag, "_idle"}, {bus.in_ready, bus.busy, bus.ser_out}, 3'b100);
  endtask

  initial begin
    vec_t       vecs[8];
    int         n;
    logic [8:0] rx;
    int         acc_edge;
    logic [8:0] model_word;
    int         d;
    bit         idle;
    logic       exp_ser;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    vecs[0] = '{9'h155, 1'b1};
    vecs[1] = '{9'h0FF, 1'b0};
    vecs[2] = '{9'h007, 1'b1};
    vecs[3] = '{9'h003, 1'b0};
    vecs[4] = '{9'h000, 1'b0};
    vecs[5] = '{9'h100, 1'b1};
    vecs[6] = '{9'h1FF, 1'b1};
    vecs[7] = '{9'h001, 1'b1};

    // Reset held for three cycles, then released between edges.
    repeat (3) tick();
    chk("rst_outputs", {bus.ser_out, bus.busy, bus.frame_sync, bus.in_ready}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_release_ready", bus.in_ready, 1);
    tick();
    chk("rst_after_edge", {bus.in_ready, bus.busy, bus.ser_out}, 3'b100);

    // Table of words, each looped back through the receiver.
    foreach (vecs[i]) run_frame(vecs[i].data, PAR_EN & vecs[i].par, $sformatf("vec%0d", i));

    // Valid held high: second accept exactly 11+G cycles after the first.
    bus.in_valid = 1'b1;
    bus.in_data  = 9'h0FF;
    tick();
    chk("b2b_first_sync", bus.frame_sync, 1);
    bus.in_data = 9'h001;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.frame_sync !== 1'b1 && n < 100);
    chk("b2b_spacing", n, 11 + G);
    bus.in_valid = 1'b0;
    rx = '0;
    for (int k = 0; k < 9; k++) begin
      rx[k] = bus.ser_out;
      tick();
    end
    chk("b2b_second_rx", rx, 9'h001);
    repeat (G + 2) tick();
    chk("b2b_idle", bus.in_ready, 1);

    // Reset in the middle of a frame aborts it asynchronously.
    bus.in_valid = 1'b1;
    bus.in_data  = 9'h1FF;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    chk("midrst_bit4", bus.ser_out, 1);
    #2;
    rst_n = 1'b1;
    #1;
    chk("midrst_abort", {bus.ser_out, bus.busy, bus.frame_sync, bus.in_ready}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (12) tick();
    chk("midrst_no_resume", {bus.ser_out, bus.busy, bus.in_ready}, 3'b001);
    run_frame(9'h1FF, PAR_EN, "midrst_clean");

    // Random traffic against a frame-timing model: accept at edge a puts bit d on the line
    // d cycles later (d=0..8), the guard at d=9, zeros through d=9+G, then ready again.
    acc_edge   = -1000;
    model_word = '0;
    for (int m = 0; m < 2000; m++) begin
      d    = m - acc_edge;
      idle = (d > 9 + G);
      if (idle)        exp_ser = 1'b0;
      else if (d <= 8) exp_ser = model_word[d];
      else if (d == 9) exp_ser = PAR_EN & (^model_word);
      else             exp_ser = 1'b0;
      chk("rnd_ser", bus.ser_out, exp_ser);
      chk("rnd_sync", bus.frame_sync, (!idle && d == 0) ? 1 : 0);
      chk("rnd_busy", bus.busy, idle ? 0 : 1);
      chk("rnd_ready", bus.in_ready, idle ? 1 : 0);
      bus.in_valid = ($urandom_range(0, 3) == 0);
      bus.in_data  = 9'($urandom);
      if (idle && bus.in_valid) begin
        acc_edge   = m + 1;
        model_word = bus.in_data;
      end
      tick();
    end
    bus.in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prob_word_serializer.md
PROB_WORD_SERIALIZER -- requirements
Module: prob_word_serializer

Interface
REQ-001 Parameter GAP_CYCLES, default 131068: number of idle cycles after each 10-bit frame before a new word is accepted.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  a 9-bit probability word is offered.
REQ-005 in_data  input  9  unsigned probability word, sampled on accept.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 ser_out  output  1  registered serial line driven to the stochastic-adder input pin.
REQ-008 frame_sync  output  1  high during the cycle ser_out carries data bit 0.
REQ-009 busy  output  1  high whenever the state is not IDLE.

Function
REQ-010 The state machine SHALL have four states: IDLE, SHIFT, GUARD and GAP.
REQ-011 In IDLE, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-012 An accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; in_data is latched into a 9-bit shift register and the state moves to SHIFT with bit_cnt=0.
REQ-013 In SHIFT, ser_out SHALL present the latched word LSB first, one bit per cycle, so bit k is on ser_out during cycle k+1 after the accept edge (k=0..8).
REQ-014 After bit 8, the state SHALL move to GUARD for exactly 1 cycle; ser_out=0 there, except as REQ-022 states.
REQ-015 After GUARD, the state SHALL move to GAP for exactly GAP_CYCLES cycles with ser_out=0, then return to IDLE.
REQ-016 Frame period, from accept to the next possible accept, SHALL be 10+GAP_CYCLES+1 cycles.
REQ-017 frame_sync SHALL be 1 only in the SHIFT cycle with bit_cnt=0.
REQ-018 in_data changes while not in IDLE SHALL have no effect on the frame in flight.
REQ-019 GAP_CYCLES=0 SHALL give GUARD -> IDLE directly; the gap counter SHALL be 17 bits wide and SHALL not wrap.

Reset
REQ-020 While rst_n=1: state=IDLE, ser_out=0, frame_sync=0, busy=0, shift register=0, counters=0; in_ready SHALL read 0 during reset and 1 from the first cycle after release.
REQ-021 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously); no partial frame resumes after release.

Configuration
REQ-022 With SER_PARITY_EN defined, the GUARD bit SHALL be the even parity (XOR) of the 9 data bits; without it, the GUARD bit SHALL be constant 0. All other timing is identical in both builds.

Structure
REQ-023 A shared package stoch_ser_pkg SHALL hold the state enum type, PROB_W=9, FRAME_BITS=10 and the default GAP_CYCLES constant, so the receiving-side modules use the same values.
REQ-024 One sub-module, ser_gap_timer (a loadable 17-bit down-counter with a done flag), SHALL implement the GAP count; shift logic and the FSM remain in the top module.

Verification
REQ-025 Reset: assert rst_n for 3 cycles -> ser_out=0, busy=0, frame_sync=0, in_ready=0; after release in_ready=1.
REQ-026 Accept in_data=9'h155 with GAP_CYCLES=4 -> ser_out=1,0,1,0,1,0,1,0,1 then guard 0, frame_sync only on the first bit, then 4 zero cycles, then in_ready=1.
REQ-027 in_valid held high, data 9'h0FF then 9'h001, GAP_CYCLES=4 -> accepts are exactly 15 cycles apart; the second frame serializes 1 followed by eight 0s.
REQ-028 Reset pulse during bit 4 of 9'h1FF -> ser_out=0 at once, state IDLE; the next accept starts a clean frame from bit 0.
REQ-029 SER_PARITY_EN defined, in_data=9'h007 -> guard bit 1; in_data=9'h003 -> guard bit 0; without the macro, guard bit 0 in both cases.
REQ-030 Loopback into the 9-bit receiver, GAP_CYCLES default, values 0, 9'h100 and 9'h1FF -> the receiver captures each value unchanged, one per frame.
